// File: rtl/mdu.sv
// rtl/mdu.sv - iterative RV32M multiply/divide unit (shift-add / restoring divide)
// Optional early-out for zero operands: MDU_FAST_ZERO_EN
module mdu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [2:0]            MulDivOp,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] MDUResult
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    acc_hi, acc_lo, opb, orig_a;
    logic [2:0]      op;
    logic            neg_res, div_zero, div_ovf;

    logic            accept, last_step, fast_in;
    logic            is_div_in, sa_in, sb_in, zero_b_in, ovf_in, neg_in;
    logic [W-1:0]    mag_a, mag_b, fast_res;
    logic [W:0]      mul_sum, div_shift, div_diff;
    logic [W-1:0]    hi_nx, lo_nx;
    logic [2*W-1:0]  prod_s;
    logic [W-1:0]    quo_s, rem_s, res_nx;

    assign accept    = Start && (state == IDLE || state == DONE);
    assign last_step = (cnt == CW'(W - 1));

    // Operand decode at capture: signedness per funct3, magnitudes and special cases
    always_comb begin
        is_div_in = MulDivOp[2];
        sa_in     = SrcA[W-1] && (MulDivOp == OP_MUL || MulDivOp == OP_MULH ||
                                  MulDivOp == OP_MULHSU || MulDivOp == OP_DIV ||
                                  MulDivOp == OP_REM);
        sb_in     = SrcB[W-1] && (MulDivOp == OP_MUL || MulDivOp == OP_MULH ||
                                  MulDivOp == OP_DIV || MulDivOp == OP_REM);
        mag_a     = sa_in ? (~SrcA + 1'b1) : SrcA;
        mag_b     = sb_in ? (~SrcB + 1'b1) : SrcB;
        zero_b_in = (SrcB == '0);
        ovf_in    = (MulDivOp == OP_DIV || MulDivOp == OP_REM) &&
                    (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
        neg_in    = (is_div_in && MulDivOp[1]) ? sa_in : (sa_in ^ sb_in);
        fast_in   = 1'b0;
        fast_res  = '0;
`ifdef MDU_FAST_ZERO_EN
        fast_in   = is_div_in ? zero_b_in : (zero_b_in || SrcA == '0);
        if (is_div_in)
            fast_res = MulDivOp[1] ? SrcA : '1;
`endif
    end

    // One datapath step; the result is formed from the post-step values so the
    // final iteration and the result load share the same edge
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        div_shift = {acc_hi, acc_lo[W-1]};
        div_diff  = div_shift - {1'b0, opb};
        if (!op[2]) begin
            hi_nx = mul_sum[W:1];
            lo_nx = {mul_sum[0], acc_lo[W-1:1]};
        end else if (!div_diff[W]) begin
            hi_nx = div_diff[W-1:0];
            lo_nx = {acc_lo[W-2:0], 1'b1};
        end else begin
            hi_nx = div_shift[W-1:0];
            lo_nx = {acc_lo[W-2:0], 1'b0};
        end

        prod_s = neg_res ? (~{hi_nx, lo_nx} + 1'b1) : {hi_nx, lo_nx};
        quo_s  = neg_res ? (~lo_nx + 1'b1) : lo_nx;
        rem_s  = neg_res ? (~hi_nx + 1'b1) : hi_nx;

        if (!op[2])
            res_nx = (op == OP_MUL) ? prod_s[W-1:0] : prod_s[2*W-1:W];
        else if (div_zero)
            res_nx = op[1] ? orig_a : '1;
        else if (div_ovf)
            res_nx = op[1] ? '0 : orig_a;
        else
            res_nx = op[1] ? rem_s : quo_s;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (Start)
                    state_nx = fast_in ? DONE : RUN;
                else
                    state_nx = IDLE;
            end
            RUN: begin
                if (last_step)
                    state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opb       <= '0;
            orig_a    <= '0;
            op        <= '0;
            neg_res   <= 1'b0;
            div_zero  <= 1'b0;
            div_ovf   <= 1'b0;
            MDUResult <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Busy <= (state_nx == RUN);
            Done <= (state_nx == DONE);
            if (accept) begin
                cnt      <= '0;
                acc_hi   <= '0;
                // Divide shifts the dividend out of acc_lo; multiply shifts the multiplier
                acc_lo   <= is_div_in ? mag_a : mag_b;
                opb      <= is_div_in ? mag_b : mag_a;
                orig_a   <= SrcA;
                op       <= MulDivOp;
                neg_res  <= neg_in;
                div_zero <= is_div_in && zero_b_in;
                div_ovf  <= ovf_in;
                if (fast_in)
                    MDUResult <= fast_res;
            end else if (state == RUN) begin
                acc_hi <= hi_nx;
                acc_lo <= lo_nx;
                cnt    <= cnt + CW'(1);
                if (last_step)
                    MDUResult <= res_nx;
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - randomized and directed self-checking bench for mdu
module tb_mdu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          Start = 1'b0;
    logic [2:0]    MulDivOp = '0;
    logic [W-1:0]  SrcA = '0;
    logic [W-1:0]  SrcB = '0;
    logic          Busy, Done;
    logic [W-1:0]  MDUResult;

    int total = 0;
    int bad   = 0;

    mdu #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .MulDivOp  (MulDivOp),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Busy      (Busy),
        .Done      (Done),
        .MDUResult (MDUResult)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        longint av, bv, p, q, r;
        logic [63:0] pb;
        case (o)
            3'b000, 3'b001: begin av = longint'($signed(a)); bv = longint'($signed(b)); end
            3'b010:         begin av = longint'($signed(a)); bv = longint'(b); end
            3'b011:         begin av = longint'(a); bv = longint'(b); end
            3'b100, 3'b110: begin av = longint'($signed(a)); bv = longint'($signed(b)); end
            default:        begin av = longint'(a); bv = longint'(b); end
        endcase
        if (!o[2]) begin
            p  = av * bv;
            pb = p;
            return (o == 3'b000) ? pb[31:0] : pb[63:32];
        end
        if (b == 0)
            return o[1] ? a : 32'hFFFF_FFFF;
        if ((o == 3'b100 || o == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'h0 : a;
        q  = av / bv;
        r  = av % bv;
        pb = o[1] ? r : q;
        return pb[31:0];
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
`ifdef MDU_FAST_ZERO_EN
        if ((o[2] && b == 0) || (!o[2] && (a == 0 || b == 0)))
            return 0;
`endif
        return W;
    endfunction

    // Launch one operation; report result, edges from capture to Done, and handshake anomalies
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output int lat, output int hs_bad);
        @(negedge clk);
        Start = 1'b1; MulDivOp = o; SrcA = a; SrcB = b;
        @(posedge clk); #1;
        Start = 1'b0;
        lat = -1; hs_bad = 0; res = 'x;
        for (int k = 0; k < 100; k++) begin
            if (Done) begin
                lat = k; res = MDUResult;
                if (Busy) hs_bad++;
                break;
            end
            if (!Busy) hs_bad++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Busy); end
        total++; if (Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", Done); end
        total++; if (MDUResult !== '0) begin bad++; $display("FAIL reset_result got=%h want=0", MDUResult); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed;
        logic [2:0]   ops [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                    3'd4, 3'd7, 3'd4, 3'd6};
        logic [W-1:0] as  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                    32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                    32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [W-1:0] bs  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2,
                                    32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                                    32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [W-1:0] ex  [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                    32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                    32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [W-1:0] res;
        int lat, hs;
        for (int i = 0; i < 12; i++) begin
            do_op(ops[i], as[i], bs[i], res, lat, hs);
            total++;
            if (res !== ex[i]) begin
                bad++; $display("FAIL directed_%0d result got=%h want=%h", i, res, ex[i]);
            end
            total++;
            if (lat != exp_lat(ops[i], as[i], bs[i])) begin
                bad++; $display("FAIL directed_%0d latency got=%0d want=%0d", i, lat,
                                exp_lat(ops[i], as[i], bs[i]));
            end
            total++;
            if (hs != 0) begin
                bad++; $display("FAIL directed_%0d handshake got=%0d want=0", i, hs);
            end
        end
    endtask

    task automatic test_random;
        logic [2:0]   o;
        logic [W-1:0] a, b, res;
        int lat, hs;
        for (int i = 0; i < 48; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: a = '0;
                2: b = 32'hFFFF_FFFF;
                3: a = 32'h8000_0000;
                4: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op(o, a, b, res, lat, hs);
            total++;
            if (res !== model(o, a, b)) begin
                bad++; $display("FAIL random_%0d op=%0d a=%h b=%h got=%h want=%h",
                                i, o, a, b, res, model(o, a, b));
            end
            total++;
            if (lat != exp_lat(o, a, b) || hs != 0) begin
                bad++; $display("FAIL random_%0d timing lat=%0d want=%0d hs=%0d",
                                i, lat, exp_lat(o, a, b), hs);
            end
        end
    endtask

    task automatic test_abort;
        @(negedge clk);
        Start = 1'b1; MulDivOp = 3'd0; SrcA = 32'd1234; SrcB = 32'd5678;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", Busy); end
        total++; if (Done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", Done); end
        total++; if (MDUResult !== '0) begin bad++; $display("FAIL abort_result got=%h want=0", MDUResult); end
        @(negedge clk);
        reset = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;
        total++; if (Done !== 1'b0 || Busy !== 1'b0) begin
            bad++; $display("FAIL abort_quiet done=%b busy=%b want=0/0", Done, Busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] a, b;
        int k1, j;
        a = $urandom | 32'd1;
        b = $urandom | 32'd1;
        @(negedge clk);
        Start = 1'b1; MulDivOp = 3'd0; SrcA = a; SrcB = b;
        @(posedge clk); #1;
        // Start stays high through RUN with changing operands; only the DONE-cycle values count
        k1 = -1;
        for (int k = 0; k < 100; k++) begin
            if (Done) begin k1 = k; break; end
            if (k < 6) begin
                MulDivOp = 3'd4; SrcA = $urandom; SrcB = $urandom;
            end else begin
                MulDivOp = 3'd0; SrcA = 32'd3; SrcB = 32'd4;
            end
            @(posedge clk); #1;
        end
        total++;
        if (k1 != W || MDUResult !== model(3'd0, a, b)) begin
            bad++; $display("FAIL b2b_first lat=%0d want=%0d got=%h want=%h",
                            k1, W, MDUResult, model(3'd0, a, b));
        end
        j = 0;
        do begin
            @(posedge clk); #1;
            j++;
            if (j == 1) Start = 1'b0;
        end while (!Done && j < 100);
        total++;
        if (j != W + 1 || MDUResult !== 32'd12) begin
            bad++; $display("FAIL b2b_second edges=%0d want=%0d got=%h want=0000000c",
                            j, W + 1, MDUResult);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
